// File: rtl/wb_pipe_if.sv
// Valid/ready stream carrying one write-back result (dest addr, write enable, data).
//   master: drives valid/wd/wreg/wdata, receives ready
//   slave : receives valid/wd/wreg/wdata, drives ready
interface wb_pipe_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;

    modport master (output valid, output wd, output wreg, output wdata, input ready);
    modport slave  (input valid, input wd, input wreg, input wdata, output ready);
endinterface

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline register with valid/ready handshake, flush and optional skid entry.
// Ports:
//   clk    : clock, all state on rising edge
//   rst    : synchronous reset, active-high
//   flush  : discard all held entries, block input this cycle
//   mem_i  : upstream result stream from MEM (slave side; ready = in_ready)
//   wb_o   : downstream result stream to WB (master side; payload zero when not valid)
module wb_pipe_stage #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter bit          SKID_EN   = 1'b1,
    parameter bit          ZERO_SUPP = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    wb_pipe_if.slave  mem_i,
    wb_pipe_if.master wb_o
);

    // Main (M) entry: the one presented on the outputs
    logic              m_valid_q, m_valid_d;
    logic [ADDR_W-1:0] m_wd_q,    m_wd_d;
    logic              m_wreg_q,  m_wreg_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

    // Skid (S) entry: always younger than M; stays empty when SKID_EN=0
    logic              s_valid_q, s_valid_d;
    logic [ADDR_W-1:0] s_wd_q,    s_wd_d;
    logic              s_wreg_q,  s_wreg_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic emit;

    // Handshake terms; flush is the only combinational input to ready in skid mode
    always_comb begin
        out_valid = m_valid_q & ~flush;
        if (SKID_EN) begin
            in_ready = ~s_valid_q & ~flush;
        end else begin
            in_ready = (~m_valid_q | wb_o.ready) & ~flush;
        end
        accept = mem_i.valid & in_ready;
        emit   = out_valid & wb_o.ready;
    end

    // Entry update; payload fields change only when their entry is reloaded
    always_comb begin
        m_valid_d = m_valid_q;
        m_wd_d    = m_wd_q;
        m_wreg_d  = m_wreg_q;
        m_wdata_d = m_wdata_q;
        s_valid_d = s_valid_q;
        s_wd_d    = s_wd_q;
        s_wreg_d  = s_wreg_q;
        s_wdata_d = s_wdata_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || emit) begin
            if (s_valid_q) begin
                // S holds the older pending beat; ready is low so nothing is accepted
                m_valid_d = 1'b1;
                m_wd_d    = s_wd_q;
                m_wreg_d  = s_wreg_q;
                m_wdata_d = s_wdata_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_wd_d    = mem_i.wd;
                m_wreg_d  = mem_i.wreg;
                m_wdata_d = mem_i.wdata;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (SKID_EN && accept) begin
            // M stalled: S absorbs the beat that was in flight while ready was still high
            s_valid_d = 1'b1;
            s_wd_d    = mem_i.wd;
            s_wreg_d  = mem_i.wreg;
            s_wdata_d = mem_i.wdata;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_wd_q    <= '0;
            m_wreg_q  <= 1'b0;
            m_wdata_q <= '0;
            s_valid_q <= 1'b0;
            s_wd_q    <= '0;
            s_wreg_q  <= 1'b0;
            s_wdata_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_wd_q    <= m_wd_d;
            m_wreg_q  <= m_wreg_d;
            m_wdata_q <= m_wdata_d;
            s_valid_q <= s_valid_d;
            s_wd_q    <= s_wd_d;
            s_wreg_q  <= s_wreg_d;
            s_wdata_q <= s_wdata_d;
        end
    end

    // Bubbles present a NOP; writes to register 0 are suppressed when enabled
    assign mem_i.ready = in_ready;
    assign wb_o.valid  = out_valid;
    assign wb_o.wd     = out_valid ? m_wd_q : '0;
    assign wb_o.wreg   = out_valid & m_wreg_q & ~(ZERO_SUPP & (m_wd_q == '0));
    assign wb_o.wdata  = out_valid ? m_wdata_q : '0;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Testbench for wb_pipe_stage: directed table on a skid instance, then randomized
// traffic on both a skid and a non-skid instance against a queue-based model.
module tb_wb_pipe_stage;

    logic clk = 1'b0;
    logic rst;
    logic flush_a;
    logic flush_b;

    always #5 clk = ~clk;

    wb_pipe_if #(.ADDR_W(5), .DATA_W(32)) a_in ();
    wb_pipe_if #(.ADDR_W(5), .DATA_W(32)) a_out ();
    wb_pipe_if #(.ADDR_W(5), .DATA_W(32)) b_in ();
    wb_pipe_if #(.ADDR_W(5), .DATA_W(32)) b_out ();

    wb_pipe_stage #(.ADDR_W(5), .DATA_W(32), .SKID_EN(1'b1), .ZERO_SUPP(1'b1)) dut_skid (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_a),
        .mem_i (a_in),
        .wb_o  (a_out)
    );

    wb_pipe_stage #(.ADDR_W(5), .DATA_W(32), .SKID_EN(1'b0), .ZERO_SUPP(1'b1)) dut_noskid (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_b),
        .mem_i (b_in),
        .wb_o  (b_out)
    );

    typedef struct {
        bit          chk;
        bit          rst;
        bit          flush;
        bit          iv;
        logic [4:0]  wd;
        bit          wreg;
        logic [31:0] wdata;
        bit          ordy;
        bit          e_irdy;
        bit          e_ov;
        logic [4:0]  e_wd;
        bit          e_wreg;
        logic [31:0] e_wdata;
    } vec_t;

    typedef struct {
        logic [4:0]  wd;
        bit          wreg;
        logic [31:0] wdata;
    } beat_t;

    int vectors     = 0;
    int miscompares = 0;
    vec_t tbl[$];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit chk, input bit r, input bit fl, input bit iv,
                                input logic [4:0] wd, input bit wreg, input logic [31:0] wdata,
                                input bit ordy, input bit e_irdy, input bit e_ov,
                                input logic [4:0] e_wd, input bit e_wreg, input logic [31:0] e_wdata);
        vec_t v;
        v.chk = chk; v.rst = r; v.flush = fl; v.iv = iv; v.wd = wd; v.wreg = wreg;
        v.wdata = wdata; v.ordy = ordy; v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_wd = e_wd;
        v.e_wreg = e_wreg; v.e_wdata = e_wdata;
        return v;
    endfunction

    // Drive one cycle on the skid instance and check its outputs before the next rising edge
    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk);
        rst         = v.rst;
        flush_a     = v.flush;
        a_in.valid  = v.iv;
        a_in.wd     = v.wd;
        a_in.wreg   = v.wreg;
        a_in.wdata  = v.wdata;
        a_out.ready = v.ordy;
        #1;
        if (v.chk) begin
            cmp({nm, ".in_ready"},  64'(a_in.ready),   64'(v.e_irdy));
            cmp({nm, ".out_valid"}, 64'(a_out.valid),  64'(v.e_ov));
            cmp({nm, ".wb_wd"},     64'(a_out.wd),     64'(v.e_wd));
            cmp({nm, ".wb_wreg"},   64'(a_out.wreg),   64'(v.e_wreg));
            cmp({nm, ".wb_wdata"},  64'(a_out.wdata),  64'(v.e_wdata));
        end
    endtask

    task automatic idle_inputs();
        flush_a = 1'b0; flush_b = 1'b0;
        a_in.valid = 1'b0; a_in.wd = '0; a_in.wreg = 1'b0; a_in.wdata = '0; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.wd = '0; b_in.wreg = 1'b0; b_in.wdata = '0; b_out.ready = 1'b0;
    endtask

    // Random traffic vs. a bounded FIFO model (capacity 2 with skid, 1 without)
    task automatic rand_phase(input bit noskid, input int n);
        beat_t q[$];
        beat_t b;
        beat_t front;
        bit iv, fl, ordy, e_ov, e_irdy;
        logic [4:0] e_wd;
        bit e_wreg;
        logic [31:0] e_wdata;
        logic a_irdy, a_ov, a_wreg;
        logic [4:0] a_wd;
        logic [31:0] a_wdata;
        string tag;

        tag = noskid ? "noskid" : "skid";
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            iv      = bit'($urandom_range(0, 1));
            fl      = ($urandom_range(0, 15) == 0);
            ordy    = ($urandom_range(0, 3) != 0);
            b.wd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            b.wreg  = bit'($urandom_range(0, 1));
            b.wdata = $urandom;
            if (noskid) begin
                flush_b = fl; b_in.valid = iv; b_in.wd = b.wd; b_in.wreg = b.wreg;
                b_in.wdata = b.wdata; b_out.ready = ordy;
            end else begin
                flush_a = fl; a_in.valid = iv; a_in.wd = b.wd; a_in.wreg = b.wreg;
                a_in.wdata = b.wdata; a_out.ready = ordy;
            end
            #1;
            e_ov   = (q.size() > 0) && !fl;
            e_irdy = noskid ? ((q.size() == 0 || ordy) && !fl) : ((q.size() < 2) && !fl);
            front  = (q.size() > 0) ? q[0] : '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0};
            e_wd    = e_ov ? front.wd : 5'd0;
            e_wreg  = e_ov && front.wreg && (front.wd != 5'd0);
            e_wdata = e_ov ? front.wdata : 32'd0;
            if (noskid) begin
                a_irdy = b_in.ready; a_ov = b_out.valid; a_wd = b_out.wd;
                a_wreg = b_out.wreg; a_wdata = b_out.wdata;
            end else begin
                a_irdy = a_in.ready; a_ov = a_out.valid; a_wd = a_out.wd;
                a_wreg = a_out.wreg; a_wdata = a_out.wdata;
            end
            cmp($sformatf("%s[%0d].in_ready", tag, i),  64'(a_irdy),  64'(e_irdy));
            cmp($sformatf("%s[%0d].out_valid", tag, i), 64'(a_ov),    64'(e_ov));
            cmp($sformatf("%s[%0d].wb_wd", tag, i),     64'(a_wd),    64'(e_wd));
            cmp($sformatf("%s[%0d].wb_wreg", tag, i),   64'(a_wreg),  64'(e_wreg));
            cmp($sformatf("%s[%0d].wb_wdata", tag, i),  64'(a_wdata), 64'(e_wdata));
            if (fl) begin
                q.delete();
            end else begin
                if (e_ov && ordy) void'(q.pop_front());
                if (iv && e_irdy) q.push_back(b);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // chk rst fl iv wd wreg wdata ordy | irdy ov wd wreg wdata
        tbl.push_back(mk(0, 1, 0, 0, 5'd0, 0, 32'h0,  1,  0, 0, 5'd0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  1,  1, 0, 5'd0, 0, 32'h0));
        // stream 1..4, one cycle latency, no gaps
        tbl.push_back(mk(1, 0, 0, 1, 5'd1, 1, 32'hA0, 1,  1, 0, 5'd0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 1, 5'd2, 1, 32'hA1, 1,  1, 1, 5'd1, 1, 32'hA0));
        tbl.push_back(mk(1, 0, 0, 1, 5'd3, 1, 32'hA2, 1,  1, 1, 5'd2, 1, 32'hA1));
        tbl.push_back(mk(1, 0, 0, 1, 5'd4, 1, 32'hA3, 1,  1, 1, 5'd3, 1, 32'hA2));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  1,  1, 1, 5'd4, 1, 32'hA3));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  1,  1, 0, 5'd0, 0, 32'h0));
        // skid absorbs 6 while 5 stalls; 7 is refused
        tbl.push_back(mk(1, 0, 0, 1, 5'd5, 1, 32'h55, 0,  1, 0, 5'd0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 1, 5'd6, 1, 32'h66, 0,  1, 1, 5'd5, 1, 32'h55));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  0,  0, 1, 5'd5, 1, 32'h55));
        tbl.push_back(mk(1, 0, 0, 1, 5'd7, 1, 32'h77, 0,  0, 1, 5'd5, 1, 32'h55));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  1,  0, 1, 5'd5, 1, 32'h55));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  1,  1, 1, 5'd6, 1, 32'h66));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  1,  1, 0, 5'd0, 0, 32'h0));
        // flush with both entries held and input presented
        tbl.push_back(mk(1, 0, 0, 1, 5'd8, 1, 32'h88, 0,  1, 0, 5'd0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 1, 5'd9, 1, 32'h99, 0,  1, 1, 5'd8, 1, 32'h88));
        tbl.push_back(mk(1, 0, 1, 1, 5'd10, 1, 32'hAA, 1, 0, 0, 5'd0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  1,  1, 0, 5'd0, 0, 32'h0));
        // write to $0 suppressed; wreg=0 passes through
        tbl.push_back(mk(1, 0, 0, 1, 5'd0, 1, 32'hFFFF_FFFF, 1, 1, 0, 5'd0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  1,  1, 1, 5'd0, 0, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 0, 0, 1, 5'd3, 0, 32'h12, 1,  1, 0, 5'd0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  1,  1, 1, 5'd3, 0, 32'h12));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  1,  1, 0, 5'd0, 0, 32'h0));
        // reset mid-stall with both entries valid
        tbl.push_back(mk(1, 0, 0, 1, 5'd11, 1, 32'hB1, 0, 1, 0, 5'd0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 1, 5'd12, 1, 32'hB2, 0, 1, 1, 5'd11, 1, 32'hB1));
        tbl.push_back(mk(1, 1, 0, 1, 5'd13, 1, 32'hB3, 0, 0, 1, 5'd11, 1, 32'hB1));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,  0,  1, 0, 5'd0, 0, 32'h0));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("row%0d", i));

        // rst together with flush on a full stage, then normal latency resumes
        run_vec(mk(1, 0, 0, 1, 5'd20, 1, 32'hC0, 0, 1, 0, 5'd0, 0, 32'h0),   "rd0");
        run_vec(mk(1, 0, 0, 1, 5'd21, 1, 32'hC1, 0, 1, 1, 5'd20, 1, 32'hC0), "rd1");
        run_vec(mk(1, 1, 1, 1, 5'd22, 1, 32'hC2, 1, 0, 0, 5'd0, 0, 32'h0),   "rd2");
        run_vec(mk(1, 0, 0, 1, 5'd23, 1, 32'hC3, 1, 1, 0, 5'd0, 0, 32'h0),   "rd3");
        run_vec(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,   1, 1, 1, 5'd23, 1, 32'hC3), "rd4");
        run_vec(mk(1, 0, 0, 0, 5'd0, 0, 32'h0,   1, 1, 0, 5'd0, 0, 32'h0),   "rd5");

        rand_phase(1'b0, 3000);
        rand_phase(1'b1, 10000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
